convolution_coprocessor_ctrl: RTL and testbench

//  Sequencing/MAC stage of the convolution coprocessor. Computes Z[n] = sum_k X[k]*Y[n-k]
//  for n = 0..size_x+size_y-2. Reads X and Y memories, drives the select of the downstream
//  2:1 operand mux (X data / Y data), consumes the mux output and writes each Z sample to Z memory.

---
 rtl/convolution_coprocessor_ctrl.sv | 142 ++++++++++++++
 tb/tb_convolution_coprocessor_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/convolution_coprocessor_ctrl.sv
// Sequencing/MAC controller for the convolution coprocessor: walks n and k,
// reads X/Y through the shared operand mux, accumulates and writes each Z[n].
module convolution_coprocessor_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] size_x,
  input  logic [ADDR_WIDTH-1:0] size_y,
  output logic [ADDR_WIDTH-1:0] mem_x_addr,
  output logic [ADDR_WIDTH-1:0] mem_y_addr,
  output logic                  op_sel,
  input  logic [DATA_WIDTH-1:0] op_data,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [ACC_WIDTH-1:0]  z_data,
  output logic                  z_we,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ADDR, S_RD_X, S_RD_Y, S_MAC, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]                n_q, n_d;
  logic [IW-1:0]                k_q, k_d;
  logic [IW-1:0]                kmax_q, kmax_d;
  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic signed [DATA_WIDTH-1:0] y_q, y_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;

  logic [IW-1:0]                  sx1, sy1, last_n, kmin, kmax_w;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic                           k_last, n_last, size_zero;

  // Index arithmetic is one bit wider so n can reach size_x+size_y-2 without wrap.
  assign sx1       = {1'b0, size_x} - IW'(1);
  assign sy1       = {1'b0, size_y} - IW'(1);
  assign last_n    = {1'b0, size_x} + {1'b0, size_y} - IW'(2);
  assign kmin      = (n_q > sy1) ? (n_q - sy1) : '0;
  assign kmax_w    = (n_q < sx1) ? n_q : sx1;
  assign k_last    = (k_q == kmax_q);
  assign n_last    = (n_q == last_n);
  assign size_zero = (size_x == '0) || (size_y == '0);
  assign prod      = x_q * y_q;

  // n-k always lies in 0..size_y-1, so the low-bit difference is exact.
  assign mem_x_addr = k_q[ADDR_WIDTH-1:0];
  assign mem_y_addr = n_q[ADDR_WIDTH-1:0] - k_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      kmax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      kmax_q  <= kmax_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = size_zero ? S_DONE : S_SETUP;
      S_SETUP: state_d = S_ADDR;
      S_ADDR:  state_d = S_RD_X;
      S_RD_X:  state_d = S_RD_Y;
      S_RD_Y:  state_d = S_MAC;
      S_MAC:   state_d = k_last ? S_WRITE : S_ADDR;
      S_WRITE: state_d = n_last ? S_DONE : S_SETUP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    n_d    = n_q;
    k_d    = k_q;
    kmax_d = kmax_q;
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = acc_q;
    unique case (state_q)
      S_IDLE:  if (start) n_d = '0;
      S_SETUP: begin
        k_d    = kmin;
        kmax_d = kmax_w;
        acc_d  = '0;
      end
      S_RD_X:  x_d = op_data;
      S_RD_Y:  y_d = op_data;
      S_MAC: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        if (!k_last) k_d = k_q + IW'(1);
      end
      S_WRITE: if (!n_last) n_d = n_q + IW'(1);
      default: ;
    endcase
  end

  always_comb begin
    op_sel = 1'b0;
    z_we   = 1'b0;
    z_addr = '0;
    z_data = '0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      S_IDLE:  ;
      S_DONE:  done = 1'b1;
      S_RD_Y: begin
        op_sel = 1'b1;
        busy   = 1'b1;
      end
      S_WRITE: begin
        z_we   = 1'b1;
        z_addr = n_q[ADDR_WIDTH-1:0];
        z_data = acc_q;
        busy   = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_convolution_coprocessor_ctrl.sv
// Randomised bench for convolution_coprocessor_ctrl: bench-side X/Y memories and
// operand mux, per-cycle expectations derived from the convolution definition.
module tb_convolution_coprocessor_ctrl;

  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int ACC  = 2*DW+AW;
  localparam int MAXC = 8192;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  size_x = '0, size_y = '0;
  logic [AW-1:0]  mem_x_addr, mem_y_addr, z_addr;
  logic           op_sel, z_we, busy, done;
  logic [DW-1:0]  op_data, xrd, yrd;
  logic [ACC-1:0] z_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mx [32];
  logic [7:0] my [32];

  bit e_busy [MAXC];
  bit e_done [MAXC];
  bit e_we   [MAXC];
  bit e_sel  [MAXC];
  int e_za   [MAXC];
  int e_zd   [MAXC];
  int z_model [64];
  int done_cyc, run_len;
  int cyc = 0;
  bit active = 1'b0;

  convolution_coprocessor_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size_x(size_x), .size_y(size_y),
    .mem_x_addr(mem_x_addr), .mem_y_addr(mem_y_addr), .op_sel(op_sel), .op_data(op_data),
    .z_addr(z_addr), .z_data(z_data), .z_we(z_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read X/Y memories and the downstream 2:1 operand mux.
  always @(posedge clk) begin
    xrd <= mx[mem_x_addr];
    yrd <= my[mem_y_addr];
  end
  assign op_data = op_sel ? yrd : xrd;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  // Expected per-cycle timeline: cycle 1 is the first SETUP after the start edge.
  task automatic build(input int sx, input int sy);
    int c, lo, hi, cnt, w, sum, a, b;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_we[i] = 0; e_sel[i] = 0; e_za[i] = 0; e_zd[i] = 0;
    end
    if (sx == 0 || sy == 0) begin
      done_cyc = 1;
    end else begin
      c = 1;
      for (int n = 0; n <= sx + sy - 2; n++) begin
        lo = (n - (sy - 1) > 0) ? n - (sy - 1) : 0;
        hi = (n < sx - 1) ? n : sx - 1;
        cnt = hi - lo + 1;
        sum = 0;
        for (int k = lo; k <= hi; k++) begin
          a = $signed(mx[k]);
          b = $signed(my[n - k]);
          sum += a * b;
        end
        z_model[n] = sum;
        e_busy[c] = 1;
        for (int j = 0; j < cnt; j++) begin
          for (int d = 0; d < 4; d++) e_busy[c + 1 + 4*j + d] = 1;
          e_sel[c + 1 + 4*j + 2] = 1;
        end
        w = c + 1 + 4*cnt;
        e_busy[w] = 1;
        e_we[w]   = 1;
        e_za[w]   = n % 32;
        e_zd[w]   = sum;
        c = w + 1;
      end
      done_cyc = c;
    end
    e_done[done_cyc] = 1;
    run_len = done_cyc + 2;
  endtask

  always @(negedge clk) begin
    if (active && cyc >= 1 && cyc <= run_len) begin
      chk("busy", busy, e_busy[cyc]);
      chk("done", done, e_done[cyc]);
      chk("z_we", z_we, e_we[cyc]);
      chk("op_sel", op_sel, e_sel[cyc]);
      if (e_we[cyc]) begin
        chk("z_addr", z_addr, e_za[cyc]);
        chk("z_data", longint'($signed(z_data)), e_zd[cyc]);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_z_we"}, z_we, 0);
    chk({tag, "_op_sel"}, op_sel, 0);
    chk({tag, "_z_addr"}, z_addr, 0);
    chk({tag, "_z_data"}, z_data, 0);
    chk({tag, "_mem_x_addr"}, mem_x_addr, 0);
    chk({tag, "_mem_y_addr"}, mem_y_addr, 0);
  endtask

  // abort != 0: pulse reset shortly after the negedge of that cycle.
  task automatic run(input int sx, input int sy, input bit hold, input int abort);
    build(sx, sy);
    @(negedge clk);
    size_x = AW'(sx);
    size_y = AW'(sy);
    start  = 1'b1;
    cyc    = 0;
    active = 1'b1;
    for (int c = 1; c <= run_len; c++) begin
      @(negedge clk);
      if (abort != 0 && c == abort) begin
        #2;
        active = 1'b0;
        start  = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
          @(negedge clk);
          chk("post_abort_done", done, 0);
          chk("post_abort_z_we", z_we, 0);
          chk("post_abort_busy", busy, 0);
        end
        return;
      end
      start = hold && (c <= done_cyc);
    end
    @(negedge clk);
    active = 1'b0;
    start  = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      mx[i] = 8'($urandom);
      my[i] = 8'($urandom);
    end
  endtask

  initial begin
    int sx, sy;
    for (int i = 0; i < 32; i++) begin mx[i] = '0; my[i] = '0; end
    #2 rst_n = 1'b0;
    #20;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mx[0] = 8'd3;
    my[0] = 8'hFE;
    build(1, 1);
    chk("pin1_done_cycle", done_cyc, 7);
    chk("pin1_z0", z_model[0], -6);
    run(1, 1, 1'b0, 0);

    mx[0] = 8'd1; mx[1] = 8'd2; mx[2] = 8'd3;
    my[0] = 8'd1; my[1] = 8'd1;
    build(3, 2);
    chk("pin2_done_cycle", done_cyc, 33);
    chk("pin2_z0", z_model[0], 1);
    chk("pin2_z1", z_model[1], 3);
    chk("pin2_z2", z_model[2], 5);
    chk("pin2_z3", z_model[3], 3);
    run(3, 2, 1'b0, 0);
    run(3, 2, 1'b1, 0);
    run(3, 2, 1'b0, 20);
    run(3, 2, 1'b0, 0);

    mx[0] = 8'h80; mx[1] = 8'h80;
    my[0] = 8'h80; my[1] = 8'h80;
    build(2, 2);
    chk("pin3_z0", z_model[0], 16384);
    chk("pin3_z1", z_model[1], 32768);
    chk("pin3_z2", z_model[2], 16384);
    run(2, 2, 1'b0, 0);

    build(0, 3);
    chk("pin4_done_cycle", done_cyc, 1);
    run(0, 3, 1'b1, 0);
    run(4, 0, 1'b0, 0);

    for (int r = 0; r < 12; r++) begin
      fill_random();
      sx = int'($urandom_range(12, 1));
      sy = int'($urandom_range(12, 1));
      run(sx, sy, 1'($urandom_range(1, 0)), 0);
    end

    for (int i = 0; i < 32; i++) begin mx[i] = 8'h80; my[i] = 8'h80; end
    run(31, 31, 1'b0, 0);
    fill_random();
    run(31, 31, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
